// File: rtl/decode_issue_ctrl_if.sv
// Bundle of fetch, resource-availability, flush and decoder-side signals
// between the fetch/issue environment and the decode issue sequencer.
interface decode_issue_ctrl_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        rob_avail;
    logic        rob_empty;
    logic        rs_alu_avail;
    logic        rs_lsu_avail;
    logic        rs_br_avail;
    logic        flush;
    logic        decode_pulse;
    logic [31:0] decode_instr;
    logic [31:0] decode_pc;
    logic        decode_available;
    logic [1:0]  issue_class;
    logic [15:0] stall_cycles;

    // Environment side: fetch, ROB/RS status and flush driver.
    modport master (
        output fetch_valid, fetch_instr, fetch_pc,
        output rob_avail, rob_empty, rs_alu_avail, rs_lsu_avail, rs_br_avail, flush,
        input  fetch_ready, decode_pulse, decode_instr, decode_pc,
        input  decode_available, issue_class, stall_cycles
    );

    // Sequencer side.
    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc,
        input  rob_avail, rob_empty, rs_alu_avail, rs_lsu_avail, rs_br_avail, flush,
        output fetch_ready, decode_pulse, decode_instr, decode_pc,
        output decode_available, issue_class, stall_cycles
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode issue sequencer: buffers fetched instructions, checks ROB and
// reservation-station room for the head entry, and issues one instruction
// per two cycles as a registered pulse with stable decoder inputs.
module decode_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clock,
    input  logic           reset,
    decode_issue_ctrl_if.slave bus
);

    typedef enum logic {
        S_READY = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    localparam logic [1:0]     C_ALU  = 2'd0;
    localparam logic [1:0]     C_LSU  = 2'd1;
    localparam logic [1:0]     C_BR   = 2'd2;
    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_instr_mem [DEPTH];
    logic [31:0]      r_pc_mem    [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_decode_instr;
    logic [31:0]      r_decode_pc;
    logic             r_decode_available;
    logic [1:0]       r_issue_class;
    logic [15:0]      r_stall_cycles;

    logic [31:0]      w_head_instr;
    logic [31:0]      w_head_pc;
    logic [1:0]       w_head_class;
    logic             w_head_fence;
    logic             w_class_avail;
    logic             w_can_issue;
    logic             w_fifo_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_stall;

    assign w_head_instr = r_instr_mem[r_rd_ptr];
    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_fence = (w_head_instr[6:0] == 7'b0001111);

    // Full blocks fetch even when a pop happens in the same cycle.
    assign w_fifo_ready = (r_count < C_FULL) && !bus.flush;
    assign w_push       = bus.fetch_valid && w_fifo_ready;

    assign w_can_issue = (r_state == S_READY) && (r_count != '0) && !bus.flush &&
                         bus.rob_avail && w_class_avail &&
                         (!w_head_fence || bus.rob_empty);

    assign w_stall = (r_state == S_READY) && (r_count != '0) && !bus.flush && !w_can_issue;

    // Map the head opcode to its reservation-station class.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps unlisted opcodes from inferring a latch.
        w_head_class = C_ALU;
        unique case (w_head_instr[6:0])
            7'b0000011, 7'b0100011:             w_head_class = C_LSU;
            7'b1100011, 7'b1101111, 7'b1100111: w_head_class = C_BR;
            default:                            w_head_class = C_ALU;
        endcase
    end

    // Select the free-slot flag of the head entry's class.
    always_comb begin
        w_class_avail = bus.rs_alu_avail;
        unique case (w_head_class)
            C_LSU:   w_class_avail = bus.rs_lsu_avail;
            C_BR:    w_class_avail = bus.rs_br_avail;
            default: w_class_avail = bus.rs_alu_avail;
        endcase
    end

    // Next-state and pop decision; flush always returns to READY without popping.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            S_READY: begin
                if (w_can_issue) begin
                    w_state_next = S_PULSE;
                    w_pop        = 1'b1;
                end
            end
            S_PULSE: w_state_next = S_READY;
        endcase
        if (bus.flush) begin
            w_state_next = S_READY;
            w_pop        = 1'b0;
        end
    end

    // State register; the pulse output is decoded from it so reset drops it at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_READY;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // FIFO storage written on push.
    always_ff @(posedge clock) begin
        // NOTE: the data array has no reset; the count alone decides which entries are valid.
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.fetch_instr;
            r_pc_mem[r_wr_ptr]    <= bus.fetch_pc;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Decoder-facing registers load only on the issue edge so they hold through the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_decode_instr     <= '0;
            r_decode_pc        <= '0;
            r_decode_available <= 1'b0;
            r_issue_class      <= C_ALU;
        end else if (bus.flush) begin
            r_decode_available <= 1'b0;
        end else if (w_pop) begin
            r_decode_instr     <= w_head_instr;
            r_decode_pc        <= w_head_pc;
            r_decode_available <= 1'b1;
            r_issue_class      <= w_head_class;
        end
    end

    // Saturating count of cycles where a queued instruction could not issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.fetch_ready      = w_fifo_ready;
    assign bus.decode_pulse     = (r_state == S_PULSE);
    assign bus.decode_instr     = r_decode_instr;
    assign bus.decode_pc        = r_decode_pc;
    assign bus.decode_available = r_decode_available;
    assign bus.issue_class      = r_issue_class;
    assign bus.stall_cycles     = r_stall_cycles;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: issue cadence, FIFO full,
// class gating, FENCE serialization, flush and asynchronous reset.
module tb_decode_issue_ctrl;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    decode_issue_ctrl_if bus ();

    decode_issue_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [31:0] alu_w [3];
    logic [31:0] full_w [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        alu_w[0] = 32'h00500093;
        alu_w[1] = 32'h00108133;
        alu_w[2] = 32'h002081B3;
        for (int i = 0; i < 5; i++) full_w[i] = 32'h00000013 + (32'(i + 1) << 20);

        reset            = 1'b1;
        bus.fetch_valid  = 1'b0;
        bus.fetch_instr  = '0;
        bus.fetch_pc     = '0;
        bus.rob_avail    = 1'b1;
        bus.rob_empty    = 1'b1;
        bus.rs_alu_avail = 1'b1;
        bus.rs_lsu_avail = 1'b1;
        bus.rs_br_avail  = 1'b1;
        bus.flush        = 1'b0;
        #2;
        check("rst_pulse", 32'(bus.decode_pulse), 0);
        check("rst_avail", 32'(bus.decode_available), 0);
        check("rst_instr", bus.decode_instr, 0);
        check("rst_pc", bus.decode_pc, 0);
        check("rst_class", 32'(bus.issue_class), 0);
        check("rst_stall", 32'(bus.stall_cycles), 0);
        check("rst_ready", 32'(bus.fetch_ready), 1);
        @(negedge clock);
        reset = 1'b0;

        // Back-to-back issue of three ALU words.
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = alu_w[0]; bus.fetch_pc = 32'h100;
        step();
        check("b2b_c1_pulse", 32'(bus.decode_pulse), 0);
        bus.fetch_instr = alu_w[1]; bus.fetch_pc = 32'h104;
        step();
        check("b2b_c2_pulse", 32'(bus.decode_pulse), 1);
        check("b2b_c2_instr", bus.decode_instr, alu_w[0]);
        check("b2b_c2_pc", bus.decode_pc, 32'h100);
        check("b2b_c2_avail", 32'(bus.decode_available), 1);
        bus.fetch_instr = alu_w[2]; bus.fetch_pc = 32'h108;
        step();
        check("b2b_c3_pulse", 32'(bus.decode_pulse), 0);
        check("b2b_c3_hold", bus.decode_instr, alu_w[0]);
        bus.fetch_valid = 1'b0;
        step();
        check("b2b_c4_pulse", 32'(bus.decode_pulse), 1);
        check("b2b_c4_instr", bus.decode_instr, alu_w[1]);
        step();
        check("b2b_c5_pulse", 32'(bus.decode_pulse), 0);
        step();
        check("b2b_c6_pulse", 32'(bus.decode_pulse), 1);
        check("b2b_c6_instr", bus.decode_instr, alu_w[2]);
        check("b2b_c6_pc", bus.decode_pc, 32'h108);
        check("b2b_class", 32'(bus.issue_class), 0);
        check("b2b_stall", 32'(bus.stall_cycles), 0);

        // FIFO full with the ROB blocked, then drain in order.
        bus.rob_avail   = 1'b0;
        bus.fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.fetch_instr = full_w[i];
            step();
            check("full_stall_fill", 32'(bus.stall_cycles), 32'(i));
        end
        check("full_ready_low", 32'(bus.fetch_ready), 0);
        bus.fetch_instr = full_w[4];
        step();
        check("full_ready_held", 32'(bus.fetch_ready), 0);
        check("full_stall_held", 32'(bus.stall_cycles), 4);
        check("full_no_pulse", 32'(bus.decode_pulse), 0);
        bus.rob_avail = 1'b1;
        step();
        check("full_pop0_pulse", 32'(bus.decode_pulse), 1);
        check("full_pop0_instr", bus.decode_instr, full_w[0]);
        check("full_ready_back", 32'(bus.fetch_ready), 1);
        step();
        bus.fetch_valid = 1'b0;
        check("full_w4_pushed_gap", 32'(bus.decode_pulse), 0);
        for (int i = 1; i < 5; i++) begin
            step();
            check("full_drain_pulse", 32'(bus.decode_pulse), 1);
            check("full_drain_instr", bus.decode_instr, full_w[i]);
            step();
        end
        check("full_stall_final", 32'(bus.stall_cycles), 4);

        // Load held back by a full LSU station while the ALU station is free.
        bus.rs_lsu_avail = 1'b0;
        bus.fetch_valid  = 1'b1;
        bus.fetch_instr  = 32'h0000A103;
        step();
        bus.fetch_valid = 1'b0;
        step();
        check("lsu_gate1", 32'(bus.decode_pulse), 0);
        step();
        check("lsu_gate2", 32'(bus.decode_pulse), 0);
        bus.rs_lsu_avail = 1'b1;
        step();
        check("lsu_pulse", 32'(bus.decode_pulse), 1);
        check("lsu_class", 32'(bus.issue_class), 1);
        check("lsu_instr", bus.decode_instr, 32'h0000A103);

        // FENCE waits for an empty ROB; reset first so the stall count starts at zero.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        bus.rob_empty   = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h0FF0000F;
        step();
        bus.fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fence_wait", 32'(bus.decode_pulse), 0);
        end
        check("fence_stall", 32'(bus.stall_cycles), 3);
        bus.rob_empty = 1'b1;
        step();
        check("fence_pulse", 32'(bus.decode_pulse), 1);
        check("fence_class", 32'(bus.issue_class), 0);
        check("fence_instr", bus.decode_instr, 32'h0FF0000F);

        // Flush during a pulse with three words queued and a push offered.
        bus.rob_avail   = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h00100093; step();
        bus.fetch_instr = 32'h00200093; step();
        bus.fetch_instr = 32'h00300093; step();
        bus.rob_avail   = 1'b1;
        bus.fetch_instr = 32'h00400093; step();
        check("fl_pre_pulse", 32'(bus.decode_pulse), 1);
        check("fl_pre_count", 32'(dut.r_count), 3);
        bus.flush       = 1'b1;
        bus.fetch_instr = 32'h00500093;
        #1;
        check("fl_ready_low", 32'(bus.fetch_ready), 0);
        step();
        check("fl_count", 32'(dut.r_count), 0);
        check("fl_pulse", 32'(bus.decode_pulse), 0);
        check("fl_avail", 32'(bus.decode_available), 0);
        check("fl_instr_hold", bus.decode_instr, 32'h00100093);
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        step();
        check("fl_dropped_pulse", 32'(bus.decode_pulse), 0);
        check("fl_dropped_count", 32'(dut.r_count), 0);
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h00208463;
        step();
        bus.fetch_valid = 1'b0;
        step();
        check("br_pulse", 32'(bus.decode_pulse), 1);
        check("br_class", 32'(bus.issue_class), 2);
        check("br_instr", bus.decode_instr, 32'h00208463);
        check("br_avail", 32'(bus.decode_available), 1);

        // Asynchronous reset in the middle of the pulse, away from any edge.
        #2;
        reset = 1'b1;
        #1;
        check("ar_pulse", 32'(bus.decode_pulse), 0);
        check("ar_avail", 32'(bus.decode_available), 0);
        check("ar_instr", bus.decode_instr, 0);
        check("ar_pc", bus.decode_pc, 0);
        check("ar_class", 32'(bus.issue_class), 0);
        check("ar_stall", 32'(bus.stall_cycles), 0);
        check("ar_ready", 32'(bus.fetch_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
